// File: rtl/uart_pkt_pkg.sv
// Shared types and helpers for the packet-level UART endpoint.
package uart_pkt_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_CSUM} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;

    // ~(sum of the lowest n bytes) mod 256; n covers cmd plus up to four data bytes
    function automatic logic [BYTE_W-1:0] checksum(input logic [5*BYTE_W-1:0] bytes, input int n);
        logic [BYTE_W-1:0] sum;
        sum = '0;
        for (int i = 0; i < 5; i++)
            if (i < n) sum = sum + bytes[i*BYTE_W +: BYTE_W];
        return ~sum;
    endfunction

endpackage

// File: rtl/uart_trx.sv
// 8N1 byte transmitter and receiver; RX start bit confirmed at half-bit, data sampled mid-bit.
module uart_trx
    import uart_pkt_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] tx_data,
    input  logic              trmt,
    output logic              tx_done,
    output logic              tx_line,
    input  logic              rx_line,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_rdy,
    input  logic              clr_rx_rdy
);

    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {PH_IDLE, PH_START, PH_BITS} rx_phase_t;

    logic              tx_active;
    logic [9:0]        tx_shift;
    logic [CW-1:0]     tx_baud;
    logic [3:0]        tx_bit;

    rx_phase_t         rx_phase;
    logic              rx_s1, rx_s2, rx_prev;
    logic [CW-1:0]     rx_baud;
    logic [3:0]        rx_bit;
    logic [BYTE_W-1:0] rx_shift;

    // Line is the low bit of a flop, so reset forces it high without delay
    assign tx_line = tx_shift[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_active <= 1'b0;
            tx_shift  <= '1;
            tx_baud   <= '0;
            tx_bit    <= '0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (!tx_active) begin
                if (trmt) begin
                    tx_shift  <= {1'b1, tx_data, 1'b0};
                    tx_active <= 1'b1;
                    tx_baud   <= '0;
                    tx_bit    <= '0;
                end
            end else if (tx_baud == FULL) begin
                tx_baud  <= '0;
                tx_shift <= {1'b1, tx_shift[9:1]};
                if (tx_bit == 4'd9) begin
                    tx_active <= 1'b0;
                    tx_done   <= 1'b1;
                end else begin
                    tx_bit <= tx_bit + 4'd1;
                end
            end else begin
                tx_baud <= tx_baud + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_prev  <= 1'b1;
            rx_phase <= PH_IDLE;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_rdy   <= 1'b0;
        end else begin
            rx_s1   <= rx_line;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
            if (clr_rx_rdy) rx_rdy <= 1'b0;
            case (rx_phase)
                PH_IDLE: begin
                    if (rx_prev && !rx_s2) begin
                        rx_phase <= PH_START;
                        rx_baud  <= '0;
                    end
                end
                PH_START: begin
                    if (rx_baud == HALF) begin
                        rx_baud  <= '0;
                        rx_bit   <= '0;
                        rx_phase <= rx_s2 ? PH_IDLE : PH_BITS;
                    end else begin
                        rx_baud <= rx_baud + CW'(1);
                    end
                end
                PH_BITS: begin
                    if (rx_baud == FULL) begin
                        rx_baud <= '0;
                        if (rx_bit == 4'd8) begin
                            // A low stop bit silently drops the byte
                            rx_phase <= PH_IDLE;
                            if (rx_s2) begin
                                rx_data <= rx_shift;
                                rx_rdy  <= 1'b1;
                            end
                        end else begin
                            rx_shift <= {rx_s2, rx_shift[BYTE_W-1:1]};
                            rx_bit   <= rx_bit + 4'd1;
                        end
                    end else begin
                        rx_baud <= rx_baud + CW'(1);
                    end
                end
                default: rx_phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_pkt_comm.sv
// Packet-level UART endpoint: cmd + DATA_BYTES in, RESP_BYTES out, inter-byte timeout.
// Define UART_PKT_CHECKSUM_EN to add a trailing checksum byte on both directions.
module uart_pkt_comm
    import uart_pkt_pkg::*;
#(
    parameter int BAUD_DIV    = 2604,
    parameter int DATA_BYTES  = 2,
    parameter int RESP_BYTES  = 1,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         RX,
    output logic                         TX,
    output logic [BYTE_W-1:0]            cmd,
    output logic [BYTE_W*DATA_BYTES-1:0] data,
    output logic                         cmd_rdy,
    input  logic                         clr_cmd_rdy,
    input  logic [BYTE_W*RESP_BYTES-1:0] resp,
    input  logic                         send_resp,
    output logic                         resp_sent,
    output logic                         tx_busy,
    output logic                         frame_err
);

    localparam int DW = BYTE_W * DATA_BYTES;
`ifdef UART_PKT_CHECKSUM_EN
    localparam int TX_BYTES = RESP_BYTES + 1;
`else
    localparam int TX_BYTES = RESP_BYTES;
`endif
    localparam int TXW   = BYTE_W * TX_BYTES;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);

    logic [BYTE_W-1:0] tx_data, rx_data;
    logic              trmt, tx_done, rx_rdy, clr_rx_rdy;

    rx_state_t         rx_state;
    logic [BYTE_W-1:0] cmd_shadow;
    logic [DW-1:0]     data_shadow;
    logic [2:0]        byte_cnt;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              pkt_done;

    tx_state_t         tx_state;
    logic [TXW-1:0]    tx_buf;
    logic [2:0]        tx_idx;

    // Every received byte is consumed in the cycle it is flagged
    assign clr_rx_rdy = rx_rdy;

    uart_trx #(.BAUD_DIV(BAUD_DIV)) u_trx (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .trmt       (trmt),
        .tx_done    (tx_done),
        .tx_line    (TX),
        .rx_line    (RX),
        .rx_data    (rx_data),
        .rx_rdy     (rx_rdy),
        .clr_rx_rdy (clr_rx_rdy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state    <= RX_IDLE;
            cmd_shadow  <= '0;
            data_shadow <= '0;
            byte_cnt    <= '0;
            tmo_cnt     <= '0;
            pkt_done    <= 1'b0;
            cmd         <= '0;
            data        <= '0;
            cmd_rdy     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            pkt_done  <= 1'b0;
            if (pkt_done) begin
                cmd  <= cmd_shadow;
                data <= data_shadow;
            end
            // Set beats clear when both land in the same cycle
            if (pkt_done)
                cmd_rdy <= 1'b1;
            else if (clr_cmd_rdy || (rx_rdy && rx_state == RX_IDLE))
                cmd_rdy <= 1'b0;

            if (rx_rdy) begin
                tmo_cnt <= '0;
                case (rx_state)
                    RX_IDLE: begin
                        cmd_shadow  <= rx_data;
                        data_shadow <= '0;
                        byte_cnt    <= '0;
                        rx_state    <= RX_DATA;
                    end
                    RX_DATA: begin
                        data_shadow <= (data_shadow << BYTE_W) | DW'(rx_data);
                        byte_cnt    <= byte_cnt + 3'd1;
                        if (byte_cnt == 3'(DATA_BYTES - 1)) begin
`ifdef UART_PKT_CHECKSUM_EN
                            rx_state <= RX_CSUM;
`else
                            rx_state <= RX_IDLE;
                            pkt_done <= 1'b1;
`endif
                        end
                    end
                    RX_CSUM: begin
                        rx_state <= RX_IDLE;
                        if (rx_data == checksum(40'({cmd_shadow, data_shadow}), DATA_BYTES + 1)) begin
                            pkt_done <= 1'b1;
                        end else begin
                            frame_err   <= 1'b1;
                            cmd_shadow  <= '0;
                            data_shadow <= '0;
                        end
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end else if (rx_state != RX_IDLE) begin
                if (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1)) begin
                    rx_state    <= RX_IDLE;
                    cmd_shadow  <= '0;
                    data_shadow <= '0;
                    tmo_cnt     <= '0;
                    frame_err   <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_buf    <= '0;
            tx_idx    <= '0;
            tx_data   <= '0;
            trmt      <= 1'b0;
            tx_busy   <= 1'b0;
            resp_sent <= 1'b0;
        end else begin
            trmt <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (send_resp) begin
`ifdef UART_PKT_CHECKSUM_EN
                        tx_buf <= {resp, checksum(40'(resp), RESP_BYTES)};
`else
                        tx_buf <= resp;
`endif
                        tx_idx    <= '0;
                        resp_sent <= 1'b0;
                        tx_busy   <= 1'b1;
                        tx_state  <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    tx_data  <= tx_buf[TXW-1 -: BYTE_W];
                    tx_buf   <= tx_buf << BYTE_W;
                    trmt     <= 1'b1;
                    tx_state <= TX_WAIT;
                end
                TX_WAIT: begin
                    if (tx_done) begin
                        if (tx_idx == 3'(TX_BYTES - 1)) begin
                            tx_busy   <= 1'b0;
                            resp_sent <= 1'b1;
                            tx_state  <= TX_IDLE;
                        end else begin
                            tx_idx   <= tx_idx + 3'd1;
                            tx_state <= TX_SEND;
                        end
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pkt_comm.sv
// Scoreboard bench for uart_pkt_comm: RX packets and TX responses checked against queued expectations.
module tb_uart_pkt_comm;

    localparam int BD = 16;
    localparam int TO = 400;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_line = 1'b1;
    logic        clr_cmd_rdy = 1'b0;
    logic        send_resp = 1'b0;
    logic [15:0] resp = '0;
    logic        tx_line, cmd_rdy, resp_sent, tx_busy, frame_err;
    logic [7:0]  cmd;
    logic [15:0] data;

    int total = 0;
    int bad = 0;
    int fe_cnt = 0;

    logic [23:0] exp_rx[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  got_tx[$];

    always #5 clk = ~clk;

    uart_pkt_comm #(
        .BAUD_DIV(BD), .DATA_BYTES(2), .RESP_BYTES(2), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .RX(rx_line), .TX(tx_line),
        .cmd(cmd), .data(data), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
        .resp(resp), .send_resp(send_resp), .resp_sent(resp_sent),
        .tx_busy(tx_busy), .frame_err(frame_err)
    );

    always @(negedge clk) if (frame_err) fe_cnt++;

    // Serial decoder for the DUT's TX line
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge tx_line);
            repeat (BD / 2) @(negedge clk);
            if (tx_line == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = tx_line;
                end
                repeat (BD) @(negedge clk);
                got_tx.push_back(b);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        rx_line = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            repeat (BD) @(negedge clk);
        end
        rx_line = 1'b1;
        repeat (BD) @(negedge clk);
    endtask

    task automatic send_packet(input logic [7:0] c, input logic [15:0] d);
        logic [7:0] s;
        exp_rx.push_back({c, d});
        send_byte(c);
        send_byte(d[15:8]);
        send_byte(d[7:0]);
`ifdef UART_PKT_CHECKSUM_EN
        s = c + d[15:8] + d[7:0];
        send_byte(~s);
`endif
    endtask

    task automatic wait_rdy_rise(input int max_cyc, output bit ok);
        logic prev;
        prev = cmd_rdy;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (cmd_rdy && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = cmd_rdy;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (tx_line !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx_line); end
        total++; if (cmd !== 8'h00) begin bad++; $display("FAIL reset_cmd got=%h exp=00", cmd); end
        total++; if (data !== 16'h0000) begin bad++; $display("FAIL reset_data got=%h exp=0000", data); end
        total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL reset_cmd_rdy got=%b exp=0", cmd_rdy); end
        total++; if (resp_sent !== 1'b0) begin bad++; $display("FAIL reset_resp_sent got=%b exp=0", resp_sent); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_tx_busy got=%b exp=0", tx_busy); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        $display("reset: checked outputs");
    endtask

    task automatic test_basic();
        bit ok;
        logic [23:0] e;
        fork
            send_packet(8'h99, 16'h5577);
            wait_rdy_rise(2000, ok);
        join
        total++; if (!ok) begin bad++; $display("FAIL basic_rdy got=0 exp=rise"); end
        e = (exp_rx.size() > 0) ? exp_rx.pop_front() : 'x;
        total++; if ({cmd, data} !== e) begin bad++; $display("FAIL basic_pkt got=%h exp=%h", {cmd, data}, e); end
        total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL basic_rdy_hold got=%b exp=1", cmd_rdy); end
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL basic_clr got=%b exp=0", cmd_rdy); end
        $display("basic: cmd=%h data=%h", cmd, data);
    endtask

    task automatic test_back_to_back();
        bit ok1, ok2;
        logic [23:0] e1, e2, r1, r2;
        int fe0;
        fe0 = fe_cnt;
        fork
            begin
                send_packet(8'h00, 16'h0000);
                send_packet(8'hFF, 16'hFFFF);
            end
            begin
                wait_rdy_rise(2000, ok1);
                r1 = {cmd, data};
                e1 = (exp_rx.size() > 0) ? exp_rx.pop_front() : 'x;
                wait_rdy_rise(2000, ok2);
                r2 = {cmd, data};
            end
        join
        e2 = (exp_rx.size() > 0) ? exp_rx.pop_front() : 'x;
        total++; if (!ok1) begin bad++; $display("FAIL b2b_rdy1 got=0 exp=rise"); end
        total++; if (r1 !== e1) begin bad++; $display("FAIL b2b_pkt1 got=%h exp=%h", r1, e1); end
        total++; if (!ok2) begin bad++; $display("FAIL b2b_rdy2 got=0 exp=rise"); end
        total++; if (r2 !== e2) begin bad++; $display("FAIL b2b_pkt2 got=%h exp=%h", r2, e2); end
        total++; if (cmd_rdy !== 1'b1) begin bad++; $display("FAIL b2b_rdy_end got=%b exp=1", cmd_rdy); end
        total++; if (fe_cnt !== fe0) begin bad++; $display("FAIL b2b_frame_err got=%0d exp=%0d", fe_cnt, fe0); end
        $display("back_to_back: pkt1=%h pkt2=%h", r1, r2);
    endtask

    task automatic test_timeout();
        bit ok;
        logic [23:0] e;
        int fe0;
        fe0 = fe_cnt;
        send_byte(8'h12);
        send_byte(8'h56);
        total++; if (fe_cnt !== fe0) begin bad++; $display("FAIL tmo_early got=%0d exp=%0d", fe_cnt, fe0); end
        repeat (TO + 20) @(negedge clk);
        total++; if (fe_cnt !== fe0 + 1) begin bad++; $display("FAIL tmo_pulse got=%0d exp=%0d", fe_cnt, fe0 + 1); end
        total++; if ({cmd, data} !== 24'hFFFFFF) begin bad++; $display("FAIL tmo_outputs got=%h exp=ffffff", {cmd, data}); end
        total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL tmo_rdy got=%b exp=0", cmd_rdy); end
        fork
            send_packet(8'h34, 16'hABCD);
            wait_rdy_rise(2000, ok);
        join
        total++; if (!ok) begin bad++; $display("FAIL tmo_resync_rdy got=0 exp=rise"); end
        e = (exp_rx.size() > 0) ? exp_rx.pop_front() : 'x;
        total++; if ({cmd, data} !== e) begin bad++; $display("FAIL tmo_resync_pkt got=%h exp=%h", {cmd, data}, e); end
        total++; if (fe_cnt !== fe0 + 1) begin bad++; $display("FAIL tmo_resync_fe got=%0d exp=%0d", fe_cnt, fe0 + 1); end
        $display("timeout: frame_err pulses=%0d resync cmd=%h data=%h", fe_cnt - fe0, cmd, data);
    endtask

    task automatic test_tx();
        bit ok;
        logic [7:0] e, g;
        resp = 16'hA55A;
        send_resp = 1'b1;
        exp_tx.push_back(8'hA5);
        exp_tx.push_back(8'h5A);
`ifdef UART_PKT_CHECKSUM_EN
        exp_tx.push_back(8'h00);
`endif
        @(negedge clk);
        send_resp = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL tx_busy_set got=%b exp=1", tx_busy); end
        total++; if (resp_sent !== 1'b0) begin bad++; $display("FAIL tx_sent_low got=%b exp=0", resp_sent); end
        resp = 16'h1234;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (resp_sent) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (!ok) begin bad++; $display("FAIL tx_resp_sent got=0 exp=1"); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL tx_busy_clr got=%b exp=0", tx_busy); end
        repeat (12 * BD) @(negedge clk);
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            g = (got_tx.size() > 0) ? got_tx.pop_front() : 'x;
            total++; if (g !== e) begin bad++; $display("FAIL tx_byte got=%h exp=%h", g, e); end
            $display("tx: byte=%h", g);
        end
        total++; if (got_tx.size() != 0) begin bad++; $display("FAIL tx_extra got=%0d exp=0 extra bytes", got_tx.size()); end
        total++; if (resp_sent !== 1'b1) begin bad++; $display("FAIL tx_sent_hold got=%b exp=1", resp_sent); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [23:0] e;
        int fe0;
        resp = 16'hA55A;
        send_resp = 1'b1;
        @(negedge clk);
        send_resp = 1'b0;
        send_byte(8'h77);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_line === 1'b0 && tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (!ok) begin bad++; $display("FAIL rstmid_tx_low got=1 exp=0 before reset"); end
        #2 rst = 1'b1;
        #1;
        total++; if (tx_line !== 1'b1) begin bad++; $display("FAIL rstmid_tx got=%b exp=1", tx_line); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", tx_busy); end
        total++; if ({cmd, data} !== 24'h000000) begin bad++; $display("FAIL rstmid_outputs got=%h exp=000000", {cmd, data}); end
        total++; if (cmd_rdy !== 1'b0 || resp_sent !== 1'b0 || frame_err !== 1'b0) begin
            bad++; $display("FAIL rstmid_flags got=%b%b%b exp=000", cmd_rdy, resp_sent, frame_err);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12 * BD) @(negedge clk);
        got_tx.delete();
        exp_tx.delete();
        fe0 = fe_cnt;
        fork
            send_packet(8'h01, 16'h0203);
            wait_rdy_rise(2000, ok);
        join
        total++; if (!ok) begin bad++; $display("FAIL rstmid_rdy got=0 exp=rise"); end
        e = (exp_rx.size() > 0) ? exp_rx.pop_front() : 'x;
        total++; if ({cmd, data} !== e) begin bad++; $display("FAIL rstmid_pkt got=%h exp=%h", {cmd, data}, e); end
        total++; if (fe_cnt !== fe0) begin bad++; $display("FAIL rstmid_fe got=%0d exp=%0d", fe_cnt, fe0); end
        $display("reset_mid: after reset cmd=%h data=%h", cmd, data);
    endtask

`ifdef UART_PKT_CHECKSUM_EN
    task automatic test_checksum();
        bit ok;
        logic [23:0] e;
        int fe0;
        fork
            begin
                exp_rx.push_back(24'h050102);
                send_byte(8'h05); send_byte(8'h01); send_byte(8'h02); send_byte(8'hF7);
            end
            wait_rdy_rise(3000, ok);
        join
        total++; if (!ok) begin bad++; $display("FAIL csum_good_rdy got=0 exp=rise"); end
        e = (exp_rx.size() > 0) ? exp_rx.pop_front() : 'x;
        total++; if ({cmd, data} !== e) begin bad++; $display("FAIL csum_good_pkt got=%h exp=%h", {cmd, data}, e); end
        fe0 = fe_cnt;
        send_byte(8'h05); send_byte(8'h01); send_byte(8'h02); send_byte(8'h00);
        repeat (20) @(negedge clk);
        total++; if (fe_cnt !== fe0 + 1) begin bad++; $display("FAIL csum_bad_fe got=%0d exp=%0d", fe_cnt, fe0 + 1); end
        total++; if (cmd_rdy !== 1'b0) begin bad++; $display("FAIL csum_bad_rdy got=%b exp=0", cmd_rdy); end
        $display("checksum: bad packet frame_err pulses=%0d", fe_cnt - fe0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_timeout();
        test_tx();
        test_reset_mid();
`ifdef UART_PKT_CHECKSUM_EN
        test_checksum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
